// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param
//   Highway / country-road intersection controller with a pedestrian walk phase.
//   Moore FSM; the lamp outputs are registered alongside the state register so
//   they always match the current state.
//
// Parameters
//   TW        phase timer width in bits
//   Y2R       yellow phase length (cycles)
//   R2G       all-red phase length (cycles)
//   HWY_MIN   minimum highway green (cycles)
//   CNTRY_MAX maximum country green (cycles)
//   WALK_LEN  pedestrian walk phase length (cycles)
//
// Ports
//   clk      rising-edge clock
//   clear    asynchronous active-low reset
//   x        country-road car sensor (1 = car waiting)
//   ped_req  pedestrian request level
//   hwy      highway light   (0 RED, 1 YELLOW, 2 GREEN)
//   cntry    country light   (same encoding)
//   walk     pedestrian walk lamp
//   state    current state code (HG=0 HY=1 AR1=2 CG=3 CY=4 AR2=5 WALK=6)
module traffic_ctrl_param #(
  parameter int unsigned TW        = 8,
  parameter int unsigned Y2R       = 3,
  parameter int unsigned R2G       = 2,
  parameter int unsigned HWY_MIN   = 8,
  parameter int unsigned CNTRY_MAX = 10,
  parameter int unsigned WALK_LEN  = 6
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       x,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_HG   = 3'd0,
    S_HY   = 3'd1,
    S_AR1  = 3'd2,
    S_CG   = 3'd3,
    S_CY   = 3'd4,
    S_AR2  = 3'd5,
    S_WALK = 3'd6
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  // Terminal counts: a phase of N cycles leaves on the edge where cnt = N-1.
  localparam logic [TW-1:0] HWY_END = TW'(HWY_MIN - 1);
  localparam logic [TW-1:0] Y_END   = TW'(Y2R - 1);
  localparam logic [TW-1:0] R_END   = TW'(R2G - 1);
  localparam logic [TW-1:0] C_END   = TW'(CNTRY_MAX - 1);
  localparam logic [TW-1:0] W_END   = TW'(WALK_LEN - 1);

  state_t        st;
  state_t        nxt;
  logic [TW-1:0] cnt;
  logic          ped_pend;

  assign state = st;

  // Lamp decode: {hwy, cntry, walk}
  function automatic logic [4:0] lamps(input state_t s);
    case (s)
      S_HG:    lamps = {GREEN,  RED,    1'b0};
      S_HY:    lamps = {YELLOW, RED,    1'b0};
      S_CG:    lamps = {RED,    GREEN,  1'b0};
      S_CY:    lamps = {RED,    YELLOW, 1'b0};
      S_WALK:  lamps = {RED,    RED,    1'b1};
      default: lamps = {RED,    RED,    1'b0};
    endcase
  endfunction

  always_comb begin
    nxt = st;
    case (st)
      S_HG:   if (cnt >= HWY_END && (x || ped_pend)) nxt = S_HY;
      S_HY:   if (cnt == Y_END) nxt = S_AR1;
      S_AR1:  if (cnt == R_END) begin
                if (ped_pend)  nxt = S_WALK;
                else if (x)    nxt = S_CG;
                else           nxt = S_HG;
              end
      S_CG:   if (!x || cnt == C_END) nxt = S_CY;
      S_CY:   if (cnt == Y_END) nxt = S_AR2;
      S_AR2:  if (cnt == R_END) nxt = S_HG;
      S_WALK: if (cnt == W_END) nxt = x ? S_CG : S_HG;
      default: nxt = S_HG;
    endcase
  end

  // Lamps are registered from the next state, so they track the state register
  // exactly while still being flop outputs.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      st       <= S_HG;
      cnt      <= '0;
      ped_pend <= 1'b0;
      hwy      <= GREEN;
      cntry    <= RED;
      walk     <= 1'b0;
    end else begin
      st <= nxt;
      {hwy, cntry, walk} <= lamps(nxt);

      if (nxt != st)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;

      // Entering WALK serves the request (and swallows a same-edge request);
      // requests are ignored while walking.
      if (nxt == S_WALK && st != S_WALK)
        ped_pend <= 1'b0;
      else if (st != S_WALK && ped_req)
        ped_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
module tb_traffic_ctrl_param;

  logic       clk;
  logic       clear;
  logic       x;
  logic       ped_req;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       walk;
  logic [2:0] state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [2:0] HG = 3'd0, HY = 3'd1, AR1 = 3'd2, CG = 3'd3,
                         CY = 3'd4, AR2 = 3'd5, WK = 3'd6;

  traffic_ctrl_param #(
    .TW(8), .Y2R(3), .R2G(2), .HWY_MIN(8), .CNTRY_MAX(10), .WALK_LEN(6)
  ) dut (
    .clk(clk), .clear(clear), .x(x), .ped_req(ped_req),
    .hwy(hwy), .cntry(cntry), .walk(walk), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] expect_of(input logic [2:0] s);
    case (s)
      HG:      expect_of = {s, 2'd2, 2'd0, 1'b0};
      HY:      expect_of = {s, 2'd1, 2'd0, 1'b0};
      CG:      expect_of = {s, 2'd0, 2'd2, 1'b0};
      CY:      expect_of = {s, 2'd0, 2'd1, 1'b0};
      WK:      expect_of = {s, 2'd0, 2'd0, 1'b1};
      default: expect_of = {s, 2'd0, 2'd0, 1'b0};
    endcase
  endfunction

  task automatic check_now(input logic [2:0] s, input string tag);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {state, hwy, cntry, walk};
    exp = expect_of(s);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed {state,hwy,cntry,walk}=%h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle, then advances one cycle; repeated n times.
  // Entered and left at a falling edge.
  task automatic phase(input logic [2:0] s, input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      check_now(s, tag);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    clear = 1'b0;
    #1;
    check_now(HG, "reset_async");
    @(negedge clk);
    check_now(HG, "reset_held");
    clear = 1'b1;
  endtask

  initial begin
    clear   = 1'b0;
    x       = 1'b0;
    ped_req = 1'b0;

    // Reset held for 5 cycles, then idle highway green for 40 cycles
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check_now(HG, "reset_hold");
    end
    clear = 1'b1;
    phase(HG, 40, "idle_hg");

    // Car waiting from reset release: full cycle with country timeout
    do_reset();
    x = 1'b1;
    phase(HG,  8,  "x_hg");
    phase(HY,  3,  "x_hy");
    phase(AR1, 2,  "x_ar1");
    phase(CG,  10, "x_cg_timeout");
    phase(CY,  3,  "x_cy");
    phase(AR2, 2,  "x_ar2");
    phase(HG,  8,  "x_hg2");
    phase(HY,  3,  "x_hy2");
    phase(AR1, 2,  "x_ar1_2");
    // Car leaves during the 4th country-green cycle
    phase(CG,  3,  "drop_cg");
    x = 1'b0;
    phase(CG,  1,  "drop_cg4");
    phase(CY,  3,  "drop_cy");
    phase(AR2, 2,  "drop_ar2");
    phase(HG,  12, "drop_hg_hold");

    // Pedestrian pulse in HG cycle 2, no car
    do_reset();
    phase(HG, 2, "ped_hg");
    ped_req = 1'b1;
    phase(HG, 1, "ped_hg_pulse");
    ped_req = 1'b0;
    phase(HG,  5, "ped_hg_rest");
    phase(HY,  3, "ped_hy");
    phase(AR1, 2, "ped_ar1");
    phase(WK,  2, "ped_walk");
    ped_req = 1'b1;                 // ignored while walking
    phase(WK,  1, "ped_walk_pulse");
    ped_req = 1'b0;
    phase(WK,  3, "ped_walk_end");
    phase(HG,  20, "ped_no_rewalk");

    // Pedestrian and car together: walk first, then country green
    x       = 1'b1;
    ped_req = 1'b1;
    phase(HG, 1, "both_hg");
    ped_req = 1'b0;
    phase(HY,  3,  "both_hy");
    phase(AR1, 2,  "both_ar1");
    phase(WK,  6,  "both_walk");
    phase(CG,  10, "both_cg");
    phase(CY,  3,  "both_cy");
    phase(AR2, 2,  "both_ar2");
    phase(HG,  8,  "both_hg2");
    phase(HY,  1,  "both_hy2");

    // Clear pulsed mid-CG with a pending pedestrian request
    do_reset();
    phase(HG,  8, "clr_hg");
    phase(HY,  3, "clr_hy");
    phase(AR1, 2, "clr_ar1");
    phase(CG,  2, "clr_cg");
    ped_req = 1'b1;
    phase(CG,  1, "clr_cg_ped");
    ped_req = 1'b0;
    phase(CG,  1, "clr_cg_pend");
    clear = 1'b0;
    #1;
    check_now(HG, "clr_async_midcg");
    @(negedge clk);
    check_now(HG, "clr_held");
    x     = 1'b0;
    clear = 1'b1;
    phase(HG, 20, "clr_pend_dropped");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
